// File: rtl/vector_exec_unit.sv
// vector_exec_unit: multi-cycle element-serial vector ALU with an internal
// NVREG x NELEM register file and a combinational element read port.
// Optional build macro: VEC_SAT_EN makes ADD/SUB saturate signed results
// (V then reports saturation events). Without it ADD/SUB wrap modulo 2^EW.
//
// state  | meaning
// S_IDLE | ready=1, waiting for start; operands latched on accept
// S_EXEC | one element computed and written per clock
// S_DONE | done=1 for one cycle, flags published on exit
module vector_exec_unit #(
  parameter int EW    = 32,
  parameter int NELEM = 4,
  parameter int NVREG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     ready,
  input  logic [2:0]               ALUControl,
  input  logic [$clog2(NVREG)-1:0] vd,
  input  logic [$clog2(NVREG)-1:0] va,
  input  logic [$clog2(NVREG)-1:0] vb,
  input  logic                     ALUSrc,
  input  logic [EW-1:0]            imm,
  output logic                     done,
  output logic [3:0]               ALUFlags,
  input  logic [$clog2(NVREG)-1:0] rd_v,
  input  logic [$clog2(NELEM)-1:0] rd_e,
  output logic [EW-1:0]            rd_data
);

  localparam int VAW = $clog2(NVREG);
  localparam int EAW = $clog2(NELEM);
  localparam logic [EAW-1:0] LAST = EAW'(NELEM - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state;
  logic [EAW-1:0]  cnt;
  logic [2:0]      op_q;
  logic [VAW-1:0]  vd_q, va_q, vb_q;
  logic            src_q;
  logic [EW-1:0]   imm_q;
  logic            acc_n, acc_z, acc_c, acc_v;

  logic [EW-1:0]   vreg [NVREG][NELEM];

  logic [EW-1:0]   a_el, b_el, b_op, res;
  logic [EW:0]     sum_ext;
  logic            is_sub, el_c, el_v, arith_ovf;

  // Element datapath: operand fetch, shared adder/subtractor, result select.
  always_comb begin
    a_el      = vreg[va_q][cnt];
    b_el      = src_q ? imm_q : vreg[vb_q][cnt];
    is_sub    = (op_q == OP_SUB);
    b_op      = is_sub ? ~b_el : b_el;
    sum_ext   = {1'b0, a_el} + {1'b0, b_op} + {{EW{1'b0}}, is_sub};
    arith_ovf = (a_el[EW-1] == b_op[EW-1]) && (sum_ext[EW-1] != a_el[EW-1]);
    res       = b_el;
    el_c      = 1'b0;
    el_v      = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res  = sum_ext[EW-1:0];
        el_c = sum_ext[EW];
        el_v = arith_ovf;
`ifdef VEC_SAT_EN
        // Overflow direction follows the sign of A: both operands share it.
        if (arith_ovf)
          res = a_el[EW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
`endif
      end
      OP_AND:  res = a_el & b_el;
      OP_OR:   res = a_el | b_el;
      default: res = b_el;
    endcase
  end

  // Register file: cleared on reset, element cnt of vd written each EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NVREG; r++)
        for (int e = 0; e < NELEM; e++)
          vreg[r][e] <= '0;
    end else if (state == S_EXEC) begin
      vreg[vd_q][cnt] <= res;
    end
  end

  // Control FSM with operand latches, flag accumulation and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      ALUFlags <= 4'b0000;
      op_q     <= '0;
      vd_q     <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      src_q    <= 1'b0;
      imm_q    <= '0;
      acc_n    <= 1'b0;
      acc_z    <= 1'b0;
      acc_c    <= 1'b0;
      acc_v    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= ALUControl;
            vd_q  <= vd;
            va_q  <= va;
            vb_q  <= vb;
            src_q <= ALUSrc;
            imm_q <= imm;
            cnt   <= '0;
            acc_n <= 1'b0;
            acc_z <= 1'b1;
            acc_c <= 1'b0;
            acc_v <= 1'b0;
            ready <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_z <= acc_z & (res == '0);
          acc_c <= acc_c | el_c;
          acc_v <= acc_v | el_v;
          cnt   <= cnt + EAW'(1);
          if (cnt == LAST) begin
            acc_n <= res[EW-1];
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          ready    <= 1'b1;
          ALUFlags <= {acc_n, acc_z, acc_c, acc_v};
          state    <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Asynchronous element read port.
  always_comb begin
    rd_data = vreg[rd_v][rd_e];
  end

endmodule
